// File: rtl/mem_rmw_responder.sv
// CPU-side load/store responder in front of a word-wide memory (Memoria).
// Sub-word stores are done as read-modify-write; misaligned or illegal requests complete with an error.
module mem_rmw_responder #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] LAST_CNT  = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        lat_write;
    logic [1:0]  lat_size;
    logic [1:0]  lat_lane;
    logic [31:0] lat_wdata;
    logic        lat_err;
    logic [1:0]  rd_cnt;

    logic        accept;
    logic        req_err;
    logic        read_done;
    logic [31:0] lane_data;
    logic [31:0] merged_word;

    assign accept    = req_valid && (state == IDLE);
    assign read_done = (state == READ) && (rd_cnt == LAST_CNT);

    always_comb begin
        req_err = 1'b0;
        case (req_size)
            SIZE_WORD: req_err = (req_addr[1:0] != 2'b00);
            SIZE_HALF: req_err = req_addr[0];
            SIZE_BYTE: req_err = 1'b0;
            default:   req_err = 1'b1;
        endcase
    end

    // Lane extraction for loads and lane insertion for sub-word stores, both from the word on mem_rdata.
    always_comb begin
        lane_data   = mem_rdata;
        merged_word = mem_rdata;
        case (lat_size)
            SIZE_HALF: begin
                lane_data = {16'h0000, mem_rdata[{lat_lane[1], 4'b0000} +: 16]};
                merged_word[{lat_lane[1], 4'b0000} +: 16] = lat_wdata[15:0];
            end
            SIZE_BYTE: begin
                lane_data = {24'h000000, mem_rdata[{lat_lane, 3'b000} +: 8]};
                merged_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
            end
            default: begin
                lane_data   = mem_rdata;
                merged_word = mem_rdata;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_wr     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (req_write && (req_size == SIZE_WORD)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (rd_cnt == LAST_CNT) begin
                    next_state = lat_write ? WRITE : RESP;
                end
            end
            WRITE: begin
                mem_wr     = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = lat_err;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Word stores load mem_wdata at accept; sub-word stores load it when the read word arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write  <= 1'b0;
            lat_size   <= 2'b00;
            lat_lane   <= 2'b00;
            lat_wdata  <= 32'h0;
            lat_err    <= 1'b0;
            rd_cnt     <= 2'b00;
            resp_rdata <= 32'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
        end else begin
            if (accept) begin
                lat_write <= req_write;
                lat_size  <= req_size;
                lat_lane  <= req_addr[1:0];
                lat_wdata <= req_wdata;
                lat_err   <= req_err;
                rd_cnt    <= 2'b00;
                mem_addr  <= {req_addr[31:2], 2'b00};
                if (req_write && (req_size == SIZE_WORD) && !req_err) begin
                    mem_wdata <= req_wdata;
                end
            end
            if (state == READ) begin
                rd_cnt <= rd_cnt + 2'd1;
            end
            if (read_done) begin
                if (lat_write) begin
                    mem_wdata <= merged_word;
                end else begin
                    resp_rdata <= lane_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rmw_responder.sv
// Bench for mem_rmw_responder: two instances (READ_LAT 1 and 3), each with its own Memoria,
// compared every cycle against a transaction-level model, plus directed literal cases.
module tb_mem_rmw_responder;

    logic clk = 1'b0;
    logic reset;
    logic load_mem;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        req_valid_a [2];
    logic        req_write_a [2];
    logic [1:0]  req_size_a  [2];
    logic [31:0] req_addr_a  [2];
    logic [31:0] req_wdata_a [2];
    logic        req_ready_a [2];
    logic        resp_valid_a[2];
    logic        resp_err_a  [2];
    logic [31:0] resp_rdata_a[2];
    logic [31:0] mem_addr_a  [2];
    logic        mem_wr_a    [2];
    logic [31:0] mem_wdata_a [2];
    logic [31:0] mem_rdata_a [2];

    mem_rmw_responder #(.READ_LAT(1)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
        .req_size(req_size_a[0]), .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .resp_valid(resp_valid_a[0]), .resp_err(resp_err_a[0]), .resp_rdata(resp_rdata_a[0]),
        .mem_addr(mem_addr_a[0]), .mem_wr(mem_wr_a[0]), .mem_wdata(mem_wdata_a[0]),
        .mem_rdata(mem_rdata_a[0])
    );

    mem_rmw_responder #(.READ_LAT(3)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
        .req_size(req_size_a[1]), .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .resp_valid(resp_valid_a[1]), .resp_err(resp_err_a[1]), .resp_rdata(resp_rdata_a[1]),
        .mem_addr(mem_addr_a[1]), .mem_wr(mem_wr_a[1]), .mem_wdata(mem_wdata_a[1]),
        .mem_rdata(mem_rdata_a[1])
    );

    // Memoria: 64 words aliased on addr[7:2]; instance 1 delivers read data two edges late.
    logic [31:0] init_mem [2][64];
    logic [31:0] memw0 [64];
    logic [31:0] memw1 [64];
    logic [31:0] pipe1_s0;
    logic [31:0] pipe1_s1;

    assign mem_rdata_a[0] = memw0[mem_addr_a[0][7:2]];
    assign mem_rdata_a[1] = pipe1_s1;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int j = 0; j < 64; j++) begin
                memw0[j] <= init_mem[0][j];
                memw1[j] <= init_mem[1][j];
            end
        end else begin
            if (mem_wr_a[0]) memw0[mem_addr_a[0][7:2]] <= mem_wdata_a[0];
            if (mem_wr_a[1]) memw1[mem_addr_a[1][7:2]] <= mem_wdata_a[1];
        end
        pipe1_s0 <= memw1[mem_addr_a[1][7:2]];
        pipe1_s1 <= pipe1_s0;
    end

    // Reference model state: one in-flight transaction per instance, described by its length n and phase k.
    logic [31:0] model_mem [2][64];
    bit          m_active [2];
    int          m_k [2];
    int          m_n [2];
    logic        m_err [2];
    logic        m_store [2];
    logic [5:0]  m_idx [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_rdata [2];
    logic [31:0] m_new_rdata [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_new_wdata [2];

    task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst=%0d actual=%h expected=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic modelAccept(input int i);
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] word;
        logic [1:0]  s;
        int          lat;
        int          sh;
        a    = req_addr_a[i];
        w    = req_wdata_a[i];
        s    = req_size_a[i];
        lat  = (i == 0) ? 1 : 3;
        word = model_mem[i][a[7:2]];
        m_err[i]       = (s == 2'b11) || (s == 2'b00 && a[1:0] != 2'b00) || (s == 2'b01 && a[0]);
        m_store[i]     = !m_err[i] && req_write_a[i];
        m_addr[i]      = a & 32'hFFFF_FFFC;
        m_idx[i]       = a[7:2];
        m_new_rdata[i] = m_rdata[i];
        m_new_wdata[i] = m_wdata[i];
        if (m_err[i]) begin
            m_n[i] = 1;
        end else if (!req_write_a[i]) begin
            m_n[i] = lat + 1;
            if (s == 2'b00) begin
                m_new_rdata[i] = word;
            end else if (s == 2'b01) begin
                sh = 16 * int'(a[1]);
                m_new_rdata[i] = (word >> sh) & 32'h0000_FFFF;
            end else begin
                sh = 8 * int'(a[1:0]);
                m_new_rdata[i] = (word >> sh) & 32'h0000_00FF;
            end
        end else if (s == 2'b00) begin
            m_n[i] = 2;
            m_new_wdata[i] = w;
        end else if (s == 2'b01) begin
            m_n[i] = lat + 2;
            sh = 16 * int'(a[1]);
            m_new_wdata[i] = (word & ~(32'h0000_FFFF << sh)) | ((w & 32'h0000_FFFF) << sh);
        end else begin
            m_n[i] = lat + 2;
            sh = 8 * int'(a[1:0]);
            m_new_wdata[i] = (word & ~(32'h0000_00FF << sh)) | ((w & 32'h0000_00FF) << sh);
        end
        m_active[i] = 1'b1;
        m_k[i]      = 1;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_rdata[i]  = 32'h0;
                m_wdata[i]  = 32'h0;
                m_addr[i]   = 32'h0;
            end
        end else if (load_mem) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 64; j++) model_mem[i][j] = init_mem[i][j];
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_active[i]) begin
                    if (m_k[i] == m_n[i]) begin
                        m_active[i] = 1'b0;
                        m_rdata[i]  = m_new_rdata[i];
                        m_wdata[i]  = m_new_wdata[i];
                        if (m_store[i]) model_mem[i][m_idx[i]] = m_new_wdata[i];
                    end else begin
                        m_k[i]++;
                    end
                end else if (req_valid_a[i]) begin
                    modelAccept(i);
                end
            end
        end
    end

    task automatic checkCycle(input int i);
        logic in_resp;
        logic exp_wr;
        logic new_wdata;
        in_resp   = m_active[i] && (m_k[i] == m_n[i]);
        exp_wr    = m_active[i] && m_store[i] && (m_k[i] == m_n[i] - 1);
        new_wdata = m_active[i] && m_store[i] && (m_k[i] >= m_n[i] - 1);
        checkOutput("req_ready", i, {31'b0, req_ready_a[i]}, {31'b0, !m_active[i]});
        checkOutput("resp_valid", i, {31'b0, resp_valid_a[i]}, {31'b0, in_resp});
        checkOutput("mem_wr", i, {31'b0, mem_wr_a[i]}, {31'b0, exp_wr});
        checkOutput("mem_addr", i, mem_addr_a[i], m_addr[i]);
        checkOutput("mem_wdata", i, mem_wdata_a[i], new_wdata ? m_new_wdata[i] : m_wdata[i]);
        checkOutput("resp_rdata", i, resp_rdata_a[i], in_resp ? m_new_rdata[i] : m_rdata[i]);
        if (in_resp) checkOutput("resp_err", i, {31'b0, resp_err_a[i]}, {31'b0, m_err[i]});
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && !load_mem) begin
            for (int i = 0; i < 2; i++) checkCycle(i);
        end
    end

    task automatic checkReset(input string tag);
        for (int i = 0; i < 2; i++) begin
            checkOutput({tag, "_ready"}, i, {31'b0, req_ready_a[i]}, 32'd1);
            checkOutput({tag, "_resp_valid"}, i, {31'b0, resp_valid_a[i]}, 32'd0);
            checkOutput({tag, "_resp_err"}, i, {31'b0, resp_err_a[i]}, 32'd0);
            checkOutput({tag, "_resp_rdata"}, i, resp_rdata_a[i], 32'd0);
            checkOutput({tag, "_mem_addr"}, i, mem_addr_a[i], 32'd0);
            checkOutput({tag, "_mem_wr"}, i, {31'b0, mem_wr_a[i]}, 32'd0);
            checkOutput({tag, "_mem_wdata"}, i, mem_wdata_a[i], 32'd0);
        end
    endtask

    // Called on a falling edge; returns on the falling edge of the response cycle (latency counted in edges).
    task automatic applyStimulus(input int i, input logic wr, input logic [1:0] sz, input logic [31:0] ad,
                                 input logic [31:0] wd, input logic hold, output int lat, output int waited,
                                 output logic err, output logic [31:0] rdata, output int wcount,
                                 output logic [31:0] waddr, output logic [31:0] wdata);
        req_valid_a[i] = 1'b1;
        req_write_a[i] = wr;
        req_size_a[i]  = sz;
        req_addr_a[i]  = ad;
        req_wdata_a[i] = wd;
        lat = 0; waited = 0; err = 1'b0; rdata = 32'h0; wcount = 0; waddr = 32'h0; wdata = 32'h0;
        while (!req_ready_a[i] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready_a[i]) begin
            checkOutput("accept_timeout", i, 32'd0, 32'd1);
            req_valid_a[i] = 1'b0;
            return;
        end
        @(negedge clk);
        lat = 1;
        if (!hold) req_valid_a[i] = 1'b0;
        while (1) begin
            if (mem_wr_a[i]) begin
                wcount++;
                waddr = mem_addr_a[i];
                wdata = mem_wdata_a[i];
            end
            if (resp_valid_a[i]) begin
                err   = resp_err_a[i];
                rdata = resp_rdata_a[i];
                break;
            end
            if (lat >= 20) begin
                checkOutput("resp_timeout", i, 32'd0, 32'd1);
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #1_000_000;
        failures++;
        $display("[TB] FAIL watchdog expired t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int          lat, waited, wc;
        logic        e;
        logic [31:0] rd, wa, wdv;
        reset    = 1'b0;
        load_mem = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_valid_a[i] = 1'b0; req_write_a[i] = 1'b0; req_size_a[i] = 2'b00;
            req_addr_a[i]  = 32'h0; req_wdata_a[i] = 32'h0;
            for (int j = 0; j < 64; j++) init_mem[i][j] = $urandom;
            init_mem[i][0] = 32'hAABB_CCDD;
        end
        #12;
        checkReset("reset");
        @(negedge clk);
        reset    = 1'b1;
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;
        @(negedge clk);

        // READ_LAT=1: byte load, half RMW, word store/load, error responses.
        applyStimulus(0, 1'b0, 2'b10, 32'h0000_0102, 32'h0, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("ldb_lat", 0, lat, 2);
        checkOutput("ldb_rdata", 0, rd, 32'h0000_00BB);
        checkOutput("ldb_err", 0, {31'b0, e}, 0);
        checkOutput("ldb_writes", 0, wc, 0);
        applyStimulus(0, 1'b1, 2'b01, 32'h0000_0102, 32'h0000_1234, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("sth_lat", 0, lat, 3);
        checkOutput("sth_writes", 0, wc, 1);
        checkOutput("sth_waddr", 0, wa, 32'h0000_0100);
        checkOutput("sth_wdata", 0, wdv, 32'h1234_CCDD);
        checkOutput("sth_err", 0, {31'b0, e}, 0);
        applyStimulus(0, 1'b1, 2'b00, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("stw_lat", 0, lat, 2);
        checkOutput("stw_writes", 0, wc, 1);
        checkOutput("stw_wdata", 0, wdv, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 2'b00, 32'h0000_0104, 32'h0, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("ldw_lat", 0, lat, 2);
        checkOutput("ldw_rdata", 0, rd, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 2'b01, 32'h0000_0101, 32'h0, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("mis_lat", 0, lat, 1);
        checkOutput("mis_err", 0, {31'b0, e}, 1);
        checkOutput("mis_writes", 0, wc, 0);
        checkOutput("mis_rdata", 0, rd, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 2'b11, 32'h0000_0100, 32'h5555_5555, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("ill_lat", 0, lat, 1);
        checkOutput("ill_err", 0, {31'b0, e}, 1);
        checkOutput("ill_writes", 0, wc, 0);
        checkOutput("ill_rdata", 0, rd, 32'hDEAD_BEEF);

        // READ_LAT=3: two loads with req_valid held high.
        applyStimulus(1, 1'b0, 2'b00, 32'h0000_0100, 32'h0, 1'b1, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("b2b1_lat", 1, lat, 4);
        checkOutput("b2b1_rdata", 1, rd, 32'hAABB_CCDD);
        applyStimulus(1, 1'b0, 2'b10, 32'h0000_0103, 32'h0, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("b2b2_idle_gap", 1, waited, 1);
        checkOutput("b2b2_lat", 1, lat, 4);
        checkOutput("b2b2_rdata", 1, rd, 32'h0000_00AA);

        // Sub-word store aborted by reset during READ.
        @(negedge clk);
        req_valid_a[1] = 1'b1; req_write_a[1] = 1'b1; req_size_a[1] = 2'b10;
        req_addr_a[1]  = 32'h0000_0109; req_wdata_a[1] = 32'h0000_0055;
        @(posedge clk);
        #2;
        reset = 1'b0;
        req_valid_a[1] = 1'b0;
        #1;
        checkReset("abort");
        @(negedge clk);
        @(negedge clk);
        checkReset("abort_hold");
        reset = 1'b1;
        @(negedge clk);
        applyStimulus(1, 1'b0, 2'b00, 32'h0000_0108, 32'h0, 1'b0, lat, waited, e, rd, wc, wa, wdv);
        checkOutput("post_rst_lat", 1, lat, 4);
        checkOutput("post_rst_rdata", 1, rd, init_mem[1][2]);
        checkOutput("post_rst_writes", 1, wc, 0);

        for (int t = 0; t < 300; t++) begin
            applyStimulus(t % 2, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                          1'($urandom_range(0, 3) == 0), lat, waited, e, rd, wc, wa, wdv);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        req_valid_a[0] = 1'b0;
        req_valid_a[1] = 1'b0;
        repeat (10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
